// File: rtl/collection_scheduler.sv
// Sequential bin-visit dispatcher: urgent-first / nearest-next selection with truck capacity tracking.
// Optional watchdog on the pickup wait is enabled by defining VISIT_TIMEOUT_EN.
module collection_scheduler #(
    parameter int NUM_BINS    = 32,
    parameter int CAP_W       = 8,
    parameter int TRUCK_CAP   = 40,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_BINS-1:0] u,
    input  logic [NUM_BINS-1:0] dist1,
    input  logic [NUM_BINS-1:0] dist0,
    input  logic [NUM_BINS-1:0] amt1,
    input  logic [NUM_BINS-1:0] amt0,
    output logic                dispatch_valid,
    input  logic                dispatch_ready,
    output logic [4:0]          dispatch_bin,
    output logic [1:0]          dispatch_amt,
    input  logic                visit_done,
    output logic                return_depot,
    output logic [CAP_W-1:0]    load,
    output logic [5:0]          visit_count,
    output logic                busy,
    output logic                done,
    output logic                fault
);

    localparam logic [CAP_W:0] CAP_LIMIT = (CAP_W+1)'(TRUCK_CAP);

    if (TRUCK_CAP < 3 || TRUCK_CAP > (1 << CAP_W) - 1) begin : g_bad_cap
        $error("collection_scheduler: TRUCK_CAP outside 3..2^CAP_W-1");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("collection_scheduler: TIMEOUT_CYC outside 1..255");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_DISPATCH, S_WAIT_VISIT, S_UNLOAD, S_DONE
    } state_t;

    state_t              state;
    logic [NUM_BINS-1:0] u_q, d1_q, d0_q, a1_q, a0_q, pending;

    logic                any_urgent, near_found;
    logic [4:0]          urg_bin, near_bin, sel_bin;
    logic [1:0]          near_dist, sel_amt;
    logic [CAP_W:0]      cap_sum;

    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        any_urgent = 1'b0;
        urg_bin    = '0;
        near_found = 1'b0;
        near_bin   = '0;
        near_dist  = 2'd3;
        for (int i = 0; i < NUM_BINS; i++) begin
            // Ascending scan: last urgent hit is the highest index, strict < keeps the lowest tie.
            if (pending[i] && u_q[i]) begin
                any_urgent = 1'b1;
                urg_bin    = 5'(i);
            end
            if (pending[i] && (!near_found || {d1_q[i], d0_q[i]} < near_dist)) begin
                near_found = 1'b1;
                near_dist  = {d1_q[i], d0_q[i]};
                near_bin   = 5'(i);
            end
        end
        sel_bin = any_urgent ? urg_bin : near_bin;
        sel_amt = {a1_q[sel_bin], a0_q[sel_bin]};
        cap_sum = {1'b0, load} + {{(CAP_W-1){1'b0}}, sel_amt};
    end

`ifdef VISIT_TIMEOUT_EN
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] wdog;
    logic       fault_q;
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (rst) begin
            // NOTE: the snapshot planes are plain flops and are cleared too, so a fresh round never sees stale bins.
            state          <= S_IDLE;
            u_q            <= '0;
            d1_q           <= '0;
            d0_q           <= '0;
            a1_q           <= '0;
            a0_q           <= '0;
            pending        <= '0;
            dispatch_valid <= 1'b0;
            dispatch_bin   <= '0;
            dispatch_amt   <= '0;
            return_depot   <= 1'b0;
            load           <= '0;
            visit_count    <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
`ifdef VISIT_TIMEOUT_EN
            wdog           <= '0;
            fault_q        <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    u_q         <= u;
                    d1_q        <= dist1;
                    d0_q        <= dist0;
                    a1_q        <= amt1;
                    a0_q        <= amt0;
                    pending     <= amt1 | amt0;
                    load        <= '0;
                    visit_count <= '0;
                    busy        <= 1'b1;
`ifdef VISIT_TIMEOUT_EN
                    fault_q     <= 1'b0;
`endif
                    state       <= S_SCAN;
                end
                S_SCAN: begin
                    if (pending == '0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        dispatch_bin <= sel_bin;
                        dispatch_amt <= sel_amt;
                        // Full truck: unload first, then the same bin wins the next scan.
                        if (cap_sum > CAP_LIMIT) begin
                            return_depot <= 1'b1;
                            state        <= S_UNLOAD;
                        end else begin
                            dispatch_valid <= 1'b1;
                            state          <= S_DISPATCH;
                        end
                    end
                end
                S_DISPATCH: if (dispatch_ready) begin
                    dispatch_valid <= 1'b0;
`ifdef VISIT_TIMEOUT_EN
                    wdog           <= '0;
`endif
                    state          <= S_WAIT_VISIT;
                end
                S_WAIT_VISIT: begin
                    if (visit_done) begin
                        load                  <= load + {{(CAP_W-2){1'b0}}, dispatch_amt};
                        pending[dispatch_bin] <= 1'b0;
                        u_q[dispatch_bin]     <= 1'b0;
                        visit_count           <= visit_count + 6'd1;
                        state                 <= S_SCAN;
                    end
`ifdef VISIT_TIMEOUT_EN
                    else if (wdog == WDOG_LAST) begin
                        fault_q               <= 1'b1;
                        pending[dispatch_bin] <= 1'b0;
                        u_q[dispatch_bin]     <= 1'b0;
                        state                 <= S_SCAN;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
`endif
                end
                S_UNLOAD: if (visit_done) begin
                    return_depot <= 1'b0;
                    load         <= '0;
                    state        <= S_SCAN;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_collection_scheduler.sv
// Self-checking bench for collection_scheduler: randomized rounds compared against a
// high-level visit-order model, plus directed ordering, stall, capacity and reset scenarios.
module tb_collection_scheduler;

    localparam int CAP = 40;

    logic        clk = 1'b0;
    logic        rst, start, dispatch_ready, visit_done;
    logic [31:0] u, dist1, dist0, amt1, amt0;
    logic        dispatch_valid, return_depot, busy, done, fault;
    logic [4:0]  dispatch_bin;
    logic [1:0]  dispatch_amt;
    logic [7:0]  load;
    logic [5:0]  visit_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit unload;
        int bin;
        int amt;
    } ev_t;

    ev_t exp_q[$];
    int  exp_load, exp_count;

    collection_scheduler #(.TRUCK_CAP(CAP)) dut (
        .clk(clk), .rst(rst), .start(start),
        .u(u), .dist1(dist1), .dist0(dist0), .amt1(amt1), .amt0(amt0),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_bin(dispatch_bin), .dispatch_amt(dispatch_amt),
        .visit_done(visit_done), .return_depot(return_depot),
        .load(load), .visit_count(visit_count),
        .busy(busy), .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "bench time limit exceeded");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Plain walk through the round: pick urgent-highest, else nearest-lowest; unload whenever the pick overflows.
    function automatic void build_model(input logic [31:0] uu, dd1, dd0, aa1, aa0);
        bit pend[32];
        int ld, t, best;
        ev_t e;
        exp_q.delete();
        ld = 0;
        exp_count = 0;
        for (int i = 0; i < 32; i++) pend[i] = (aa1[i] | aa0[i]);
        forever begin
            t = -1;
            for (int i = 31; i >= 0; i--)
                if (t < 0 && pend[i] && uu[i]) t = i;
            if (t < 0) begin
                best = 4;
                for (int i = 0; i < 32; i++)
                    if (pend[i] && int'({dd1[i], dd0[i]}) < best) begin
                        best = int'({dd1[i], dd0[i]});
                        t = i;
                    end
            end
            if (t < 0) break;
            e.bin = t;
            e.amt = int'({aa1[t], aa0[t]});
            if (ld + e.amt > CAP) begin
                e.unload = 1'b1;
                exp_q.push_back(e);
                ld = 0;
            end
            e.unload = 1'b0;
            exp_q.push_back(e);
            ld += e.amt;
            exp_count++;
            pend[t] = 1'b0;
        end
        exp_load = ld;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, dispatch_valid, 0);
        check({tag, "_bin"}, dispatch_bin, 0);
        check({tag, "_amt"}, dispatch_amt, 0);
        check({tag, "_depot"}, return_depot, 0);
        check({tag, "_load"}, load, 0);
        check({tag, "_count"}, visit_count, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_fault"}, fault, 0);
    endtask

    // Runs one round against the model; abort_after >= 0 applies reset while that visit is in WAIT_VISIT.
    task automatic run_round(input logic [31:0] uu, dd1, dd0, aa1, aa0,
                             input int stall_max, input int abort_after);
        int n, stall, served, run_load;
        ev_t e;
        build_model(uu, dd1, dd0, aa1, aa0);
        served = 0;
        run_load = 0;
        @(negedge clk);
        u = uu; dist1 = dd1; dist0 = dd0; amt1 = aa1; amt0 = aa0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        u = $urandom; dist1 = $urandom; dist0 = $urandom; amt1 = $urandom; amt0 = $urandom;
        check("busy_after_start", busy, 1);
        check("no_valid_in_scan", dispatch_valid, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            e = exp_q[k];
            n = 0;
            while (!(dispatch_valid || return_depot || done) && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("event_wait_bound", n < 40, 1);
            if (e.unload) begin
                check("unload_flag", return_depot, 1);
                check("unload_no_valid", dispatch_valid, 0);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                check("unload_hold", return_depot, 1);
                visit_done = 1'b1;
                @(negedge clk);
                visit_done = 1'b0;
                check("unload_load_zero", load, 0);
                check("unload_depot_drop", return_depot, 0);
                run_load = 0;
            end else begin
                check("disp_valid", dispatch_valid, 1);
                check("disp_bin", dispatch_bin, e.bin);
                check("disp_amt", dispatch_amt, e.amt);
                check("disp_no_depot", return_depot, 0);
                stall = (k == 0) ? stall_max : $urandom_range(0, stall_max);
                for (int s = 0; s < stall; s++) begin
                    dispatch_ready = 1'b0;
                    visit_done = 1'($urandom_range(0, 1));
                    start = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    check("stall_valid", dispatch_valid, 1);
                    check("stall_bin", dispatch_bin, e.bin);
                    check("stall_amt", dispatch_amt, e.amt);
                end
                dispatch_ready = 1'b1;
                start = 1'b0;
                visit_done = 1'($urandom_range(0, 1));
                @(negedge clk);
                dispatch_ready = 1'b0;
                visit_done = 1'b0;
                check("accept_valid_drop", dispatch_valid, 0);
                if (served == abort_after) begin
                    rst = 1'b1;
                    start = 1'b1;
                    visit_done = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    start = 1'b0;
                    visit_done = 1'b0;
                    check_all_zero("midreset");
                    return;
                end
                repeat ($urandom_range(0, 3)) @(negedge clk);
                check("wait_load_unchanged", load, run_load);
                visit_done = 1'b1;
                @(negedge clk);
                visit_done = 1'b0;
                run_load += e.amt;
                served++;
                check("visit_load", load, run_load);
                check("visit_count", visit_count, served);
            end
        end
        n = 0;
        while (!done && n < 10) begin
            @(negedge clk);
            check("no_valid_before_done", dispatch_valid, 0);
            n++;
        end
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("final_load", load, exp_load);
        check("final_count", visit_count, exp_count);
        check("final_fault", fault, 0);
        @(negedge clk);
        check("done_clear", done, 0);
        check("idle_busy", busy, 0);
        check("hold_load", load, exp_load);
        check("hold_count", visit_count, exp_count);
    endtask

    initial begin
        logic [31:0] ra1, ra0, rd1, rd0;
        rst = 1'b1; start = 1'b0; dispatch_ready = 1'b0; visit_done = 1'b0;
        u = '0; dist1 = '0; dist0 = '0; amt1 = '0; amt0 = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Urgent ordering: bins 20 then 3, then nearest sweep 0,1,2,4,...
        run_round(32'h0010_0008, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF, 0, -1);

        // Nearest tie-break among bins 5 (d3), 9 (d1), 12 (d1).
        rd1 = $urandom; rd0 = $urandom;
        rd1[5] = 1'b1; rd0[5] = 1'b1;
        rd1[9] = 1'b0; rd0[9] = 1'b1;
        rd1[12] = 1'b0; rd0[12] = 1'b1;
        run_round(32'h0, rd1, rd0, 32'h0000_1220, 32'h0, 1, -1);

        // Capacity: every bin holds 3, total 96 forces repeated depot trips.
        run_round(32'h0, $urandom, $urandom, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, -1);

        // Long handshake stall on the first dispatch.
        run_round($urandom, $urandom, $urandom, $urandom, $urandom, 10, -1);

        // Randomized rounds.
        for (int r = 0; r < 4; r++)
            run_round($urandom & $urandom, $urandom, $urandom, $urandom, $urandom, 3, -1);

        // Reset mid-round while the third visit is pending.
        run_round($urandom, $urandom, $urandom, $urandom, 32'hFFFF_FFFF, 1, 2);

        // Empty round: done exactly two cycles after start, no dispatch.
        @(negedge clk);
        amt1 = '0; amt0 = '0; u = $urandom;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("empty_scan_done", done, 0);
        @(negedge clk);
        check("empty_done", done, 1);
        check("empty_no_valid", dispatch_valid, 0);
        check("empty_load", load, 0);
        check("empty_count", visit_count, 0);
        @(negedge clk);
        check("empty_done_clear", done, 0);
        check("empty_idle", busy, 0);

        // Recovery after reset with sparse amounts.
        ra1 = $urandom & $urandom; ra0 = $urandom;
        run_round($urandom & $urandom & $urandom, $urandom, $urandom, ra1, ra0, 2, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/collection_scheduler.md
Name: collection_scheduler

Overview:
- Sequential dispatcher for the 32-bin garbage collection datapath.
- On `start`, snapshots the per-bin urgency, distance and amount bit-planes.
- Repeatedly selects the next bin: urgent first, else nearest. Hands each pick to the truck over a valid/ready handshake and waits for pickup completion.
- Tracks truck load against capacity, forces depot unload trips when needed, and finishes when no pending bin remains.

Parameters:
- NUM_BINS, 32, number of bins; fixed at 32, index width 5.
- CAP_W, 8, width of the load accumulator.
- TRUCK_CAP, 40, truck capacity in amount units; legal range 3..2^CAP_W-1.
- TIMEOUT_CYC, 255, watchdog limit in WAIT_VISIT; used only with VISIT_TIMEOUT_EN.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, begin a collection round; sampled only in IDLE.
- u, input, 32, urgency flag per bin.
- dist1 / dist0, input, 32 each, distance bit-planes; bin i distance = {dist1[i],dist0[i]}, range 0..3.
- amt1 / amt0, input, 32 each, amount bit-planes; bin i amount = {amt1[i],amt0[i]}, range 0..3.
- dispatch_valid, output, 1, a bin visit is offered to the truck.
- dispatch_ready, input, 1, truck accepts the offered visit.
- dispatch_bin, output, 5, index of the offered bin.
- dispatch_amt, output, 2, amount of the offered bin.
- visit_done, input, 1, truck finished the current pickup or unload.
- return_depot, output, 1, truck must unload at the depot.
- load, output, CAP_W, current truck load.
- visit_count, output, 6, bins served this round.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse when the round completes.
- fault, output, 1, sticky watchdog flag; tied 0 without VISIT_TIMEOUT_EN.

Behaviour:
- Reset: synchronous; wins over every other input in the same cycle, including in mid-round.
  - Forces IDLE.
  - All outputs 0.
  - Snapshot registers, pending mask, load and visit_count cleared.
- States: IDLE, SCAN, DISPATCH, WAIT_VISIT, UNLOAD, DONE.
- IDLE, on start=1:
  - Snapshot u, dist and amt.
  - pending[i] = (amount != 0).
  - load=0, visit_count=0, fault=0.
  - Next state SCAN.
  - start is ignored in all other states; inputs u, dist and amt are ignored after the snapshot.
- SCAN (exactly 1 cycle):
  - If pending == 0: go to DONE.
  - Else select target:
    - If any pending bin has its snapshot urgency set: the highest such index.
    - Else: the pending bin with minimum distance; ties resolve to the lowest index.
  - Register target index and amount.
  - If load + amount > TRUCK_CAP: go to UNLOAD. Else: go to DISPATCH.
  - The capacity sum is computed at CAP_W+1 bits, with no wrap.
- DISPATCH:
  - dispatch_valid=1; dispatch_bin and dispatch_amt held stable until the handshake completes.
  - Accept happens in a cycle where dispatch_valid && dispatch_ready: go to WAIT_VISIT; dispatch_valid drops the next cycle.
  - Minimum latency: start to first dispatch_valid is 2 cycles (IDLE→SCAN→DISPATCH).
- WAIT_VISIT, on visit_done=1:
  - load += amount.
  - Clear pending and snapshot urgency for the target.
  - visit_count += 1.
  - Next state SCAN.
- UNLOAD:
  - return_depot=1 until visit_done=1.
  - Then load=0, next state SCAN; the same bin is reselected.
  - Because TRUCK_CAP ≥ 3, a bin never triggers two consecutive unloads.
- DONE: done=1 for one cycle, then IDLE. load and visit_count keep their values until the next start.
- Ignored inputs:
  - visit_done outside WAIT_VISIT/UNLOAD.
  - dispatch_ready outside DISPATCH.
- Simultaneous events:
  - visit_done asserted in the same cycle as entry into WAIT_VISIT is not seen until the following cycle.
  - Only one handshake completes per state.

Optional Feature:
- Macro: VISIT_TIMEOUT_EN.
- When defined:
  - An 8-bit watchdog counts cycles in WAIT_VISIT.
  - If it reaches TIMEOUT_CYC without visit_done: set fault (sticky until the next start or reset), clear pending for the target without adding to load or visit_count, and return to SCAN.
  - The counter resets on every entry to WAIT_VISIT.
- When undefined:
  - No counter is built; fault is tied 0.
  - WAIT_VISIT waits indefinitely.

Test Plan:
- Urgent ordering: amt all 1, u bits 3 and 20 set, dist all 2, ready/visit_done immediate → dispatch_bin order 20, 3, then 0,1,2,4,…; visit_count=32; load=32; one done pulse.
- Nearest tie-break: u=0; only bins 5, 9, 12 have amount 2; dist5=3, dist9=1, dist12=1 → dispatch order 9, 12, 5; final load=6.
- Capacity/unload: TRUCK_CAP=4; bins 0–2 amount 3; u=0; dist equal → dispatch 0, then return_depot (3+3>4), load→0, dispatch 1, unload, dispatch 2; final load=3.
- Handshake stall: hold dispatch_ready=0 for 10 cycles → dispatch_valid stays 1 with dispatch_bin and dispatch_amt unchanged; visit_done pulses during the stall are ignored.
- Reset mid-round: assert rst in WAIT_VISIT after 2 visits → next cycle IDLE with all outputs 0; a new start with an all-zero amt produces a done pulse 2 cycles later and no dispatch.
- VISIT_TIMEOUT_EN, TIMEOUT_CYC=8: never assert visit_done for bin 7 → after 8 cycles fault=1, bin 7 is skipped, the round continues, and visit_count excludes bin 7.
